// File: rtl/bg_pixel_fetch_if.sv
// Pixel-side bus of bg_pixel_fetch: scan coordinates and syncs in, ROM address/data, RGB444 and syncs out.
// master = timing generator plus background ROM; slave = bg_pixel_fetch.
interface bg_pixel_fetch_if;
   logic        pix_en;
   logic [9:0]  col;
   logic [8:0]  row;
   logic        video_on;
   logic        hs_in;
   logic        vs_in;
   logic        run;
   logic [14:0] rom_addr;
   logic [15:0] rom_data;
   logic [11:0] rgb;
   logic        hs_out;
   logic        vs_out;
   logic [7:0]  x_off;

   modport master (
      output pix_en, col, row, video_on, hs_in, vs_in, run, rom_data,
      input  rom_addr, rgb, hs_out, vs_out, x_off
   );

   modport slave (
      input  pix_en, col, row, video_on, hs_in, vs_in, run, rom_data,
      output rom_addr, rgb, hs_out, vs_out, x_off
   );
endinterface

// File: rtl/bg_pixel_fetch.sv
// Two-stage background fetch: 4x-upscaled ROM addressing, RGB565->RGB444, hsync/vsync kept aligned with rgb.
// Define BG_SCROLL_EN to build the wrapping horizontal scroll (IDLE/SCROLL FSM and x_off register).
module bg_pixel_fetch #(
   parameter int SRC_W       = 160,
   parameter int SRC_H       = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int SCROLL_STEP = 1
) (
   input logic             clk,
   input logic             rstn,
   bg_pixel_fetch_if.slave bus
);

   localparam logic [14:0] SRC_W_A = 15'(SRC_W);

   logic [14:0] sx;
   logic [14:0] sy;
   logic [14:0] row_base;
   logic [14:0] px;
   logic [14:0] rom_addr_d, rom_addr_q;
   logic [11:0] rgb_d, rgb_q;
   logic        vid1_q, hs1_q, vs1_q;
   logic        hs_out_q, vs_out_q;

   assign sx = 15'(bus.col >> SCALE_SHIFT);
   assign sy = 15'(bus.row >> SCALE_SHIFT);

   // The native 160x120 layout uses a shift-add multiply (160 = 128 + 32).
   generate
      if (SRC_W == 160 && SRC_H == 120) begin : g_mul_shift
         assign row_base = (sy << 7) + (sy << 5);
      end else begin : g_mul_generic
         assign row_base = sy * SRC_W_A;
      end
   endgenerate

`ifdef BG_SCROLL_EN
   typedef enum logic {
      IDLE,
      SCROLL
   } scroll_state_e;

   localparam logic [7:0] WRAP_AT = 8'(SRC_W - SCROLL_STEP);
   localparam logic [7:0] STEP    = 8'(SCROLL_STEP);

   scroll_state_e state_q, state_d;
   logic [7:0]    x_off_q, x_off_d, x_off_next;
   logic          vs_prev_q;
   logic          frame_edge;
   logic [14:0]   px_sum;

   assign frame_edge = bus.pix_en && vs_prev_q && !bus.vs_in;
   // Compare before adding so the wrapped offset never needs a wider intermediate.
   assign x_off_next = (x_off_q >= WRAP_AT) ? x_off_q - WRAP_AT : x_off_q + STEP;

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a next-state undriven (no latches).
      state_d = state_q;
      x_off_d = x_off_q;
      case (state_q)
         IDLE: begin
            if (frame_edge && bus.run) begin
               state_d = SCROLL;
               x_off_d = x_off_next;
            end
         end
         SCROLL: begin
            if (frame_edge) begin
               if (bus.run) x_off_d = x_off_next;
               else         state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         x_off_q   <= '0;
         vs_prev_q <= 1'b1;
      end else begin
         state_q <= state_d;
         x_off_q <= x_off_d;
         if (bus.pix_en) vs_prev_q <= bus.vs_in;
      end
   end

   // Both operands are below SRC_W, so one conditional subtract wraps the column.
   assign px_sum    = sx + 15'(x_off_q);
   assign px        = (px_sum >= SRC_W_A) ? px_sum - SRC_W_A : px_sum;
   assign bus.x_off = x_off_q;
`else
   localparam int unused_step = SCROLL_STEP;
   logic unused_run;

   assign unused_run = bus.run;
   assign px         = sx;
   assign bus.x_off  = '0;
`endif

   assign rom_addr_d = bus.video_on ? row_base + px : '0;
   assign rgb_d      = vid1_q ? {bus.rom_data[15:12], bus.rom_data[10:7], bus.rom_data[4:1]}
                              : 12'h000;

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and checked before pix_en, so it lands on the next edge mid-frame.
      if (!rstn) begin
         rom_addr_q <= '0;
         vid1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         rgb_q      <= '0;
         hs_out_q   <= 1'b1;
         vs_out_q   <= 1'b1;
      end else if (bus.pix_en) begin
         // NOTE: non-blocking, so stage 2 consumes the stage-1 values from before this strobe.
         rom_addr_q <= rom_addr_d;
         vid1_q     <= bus.video_on;
         hs1_q      <= bus.hs_in;
         vs1_q      <= bus.vs_in;
         rgb_q      <= rgb_d;
         hs_out_q   <= hs1_q;
         vs_out_q   <= vs1_q;
      end
   end

   logic unused_rom_lsbs;
   assign unused_rom_lsbs = ^{bus.rom_data[11], bus.rom_data[6:5], bus.rom_data[0]};

   assign bus.rom_addr = rom_addr_q;
   assign bus.rgb      = rgb_q;
   assign bus.hs_out   = hs_out_q;
   assign bus.vs_out   = vs_out_q;

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Self-checking bench for bg_pixel_fetch: directed addressing/colour/scroll cases plus random scans
// against a strobe-level reference model; the ROM is a hash of the address unless a test forces a word.
module tb_bg_pixel_fetch;
   localparam int SRC_W = 160;
   localparam int SCALE = 4;
   localparam int STEP  = 1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bg_pixel_fetch_if bus ();

   bg_pixel_fetch dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   logic        rom_force     = 1'b0;
   logic [15:0] rom_force_val = 16'h0000;

   function automatic logic [15:0] rom_word(input logic [14:0] a);
      return 16'((int'(a) * 40503 + 12345) % 65536);
   endfunction

   assign bus.rom_data = rom_force ? rom_force_val : rom_word(bus.rom_addr);

   // Reference RGB565 -> RGB444: keep the top 4 bits of each channel.
   function automatic logic [11:0] conv(input logic [15:0] d);
      int r, g, b;
      r = (int'(d) / 2048) / 2;
      g = ((int'(d) / 32) % 64) / 4;
      b = (int'(d) % 32) / 2;
      return 12'(r * 256 + g * 16 + b);
   endfunction

   function automatic int exp_addr(input int c, input int r, input bit von, input int xoff);
      if (!von) return 0;
      return (r / SCALE) * SRC_W + ((c / SCALE + xoff) % SRC_W);
   endfunction

   int total = 0;
   int bad   = 0;

   int          m_addr, m_xoff;
   bit          m_vid, m_hs1, m_vs1, m_hs_o, m_vs_o, m_vs_prev;
   logic [11:0] m_rgb;

   task automatic model_reset();
      m_addr = 0; m_vid = 0; m_hs1 = 1; m_vs1 = 1;
      m_rgb = 12'h000; m_hs_o = 1; m_vs_o = 1;
      m_xoff = 0; m_vs_prev = 1;
   endtask

   task automatic model_edge(input int c, input int r, input bit von, input bit hs,
                             input bit vs, input bit rn, input bit pe);
      logic [15:0] w;
      if (!rstn) begin
         model_reset();
      end else if (pe) begin
         w      = rom_force ? rom_force_val : rom_word(15'(m_addr));
         m_rgb  = m_vid ? conv(w) : 12'h000;
         m_hs_o = m_hs1;
         m_vs_o = m_vs1;
         m_addr = exp_addr(c, r, von, m_xoff);
         m_vid  = von;
         m_hs1  = hs;
         m_vs1  = vs;
`ifdef BG_SCROLL_EN
         if (m_vs_prev && !vs && rn) m_xoff = (m_xoff + STEP) % SRC_W;
`endif
         m_vs_prev = vs;
      end
   endtask

   // One pix_en strobe followed by one idle clock.
   task automatic drive(input int c, input int r, input bit von, input bit hs,
                        input bit vs, input bit rn, input bit pe);
      @(negedge clk);
      bus.col = 10'(c); bus.row = 9'(r); bus.video_on = von;
      bus.hs_in = hs; bus.vs_in = vs; bus.run = rn; bus.pix_en = pe;
      @(posedge clk);
      model_edge(c, r, von, hs, vs, rn, pe);
      @(negedge clk);
      bus.pix_en = 1'b0;
      @(posedge clk);
      model_edge(c, r, von, hs, vs, rn, 1'b0);
      #1;
   endtask

   task automatic idle_clocks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.col = 10'($urandom_range(799)); bus.row = 9'($urandom_range(524));
         bus.video_on = 1'($urandom); bus.hs_in = 1'($urandom);
         bus.vs_in = 1'($urandom); bus.run = 1'($urandom); bus.pix_en = 1'b0;
         @(posedge clk);
         model_edge(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         #1;
      end
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      rstn = 1'b1;
   endtask

   task automatic frame_edge(input bit rn);
      drive(0, 500, 1'b0, 1'b1, 1'b1, rn, 1'b1);
      drive(0, 500, 1'b0, 1'b1, 1'b0, rn, 1'b1);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int i = 0; i < 3; i++)
         drive($urandom_range(639), $urandom_range(479), 1'b1, 1'b0, 1'b0, 1'b1, 1'(i % 2 == 0));
      total++; if (bus.rom_addr !== 15'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
      total++; if (bus.rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", bus.rgb); end
      total++; if (bus.hs_out !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b exp=1", bus.hs_out); end
      total++; if (bus.vs_out !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b exp=1", bus.vs_out); end
      total++; if (bus.x_off !== 8'd0) begin bad++; $display("FAIL reset_xoff got=%0d exp=0", bus.x_off); end
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) drive(40 + 8 * i, 44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      rstn = 1'b0;
      drive(100, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      total++; if (bus.rom_addr !== 15'd0) begin bad++; $display("FAIL midreset_addr got=%0d exp=0", bus.rom_addr); end
      total++; if (bus.rgb !== 12'h000) begin bad++; $display("FAIL midreset_rgb got=%h exp=000", bus.rgb); end
      total++; if (bus.hs_out !== 1'b1) begin bad++; $display("FAIL midreset_hs got=%b exp=1", bus.hs_out); end
      total++; if (bus.vs_out !== 1'b1) begin bad++; $display("FAIL midreset_vs got=%b exp=1", bus.vs_out); end
      total++; if (bus.x_off !== 8'd0) begin bad++; $display("FAIL midreset_xoff got=%0d exp=0", bus.x_off); end
      rstn = 1'b1;
   endtask

   task automatic test_address();
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd0) begin bad++; $display("FAIL addr_origin got=%0d exp=0", bus.rom_addr); end
      drive(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd19199) begin bad++; $display("FAIL addr_corner got=%0d exp=19199", bus.rom_addr); end
      drive(4, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd161) begin bad++; $display("FAIL addr_4_4 got=%0d exp=161", bus.rom_addr); end
      drive(639, 479, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd0) begin bad++; $display("FAIL addr_blank got=%0d exp=0", bus.rom_addr); end
   endtask

   task automatic test_colour();
      logic [15:0] words [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
      logic [11:0] want  [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h000};
      bit          von   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rom_force = 1'b1; rom_force_val = words[i];
         drive(8, 8, von[i], 1'b0, 1'b1, 1'b0, 1'b1);
         drive(12, 12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         total++; if (bus.rgb !== want[i]) begin bad++; $display("FAIL colour_%0d rgb got=%h exp=%h", i, bus.rgb, want[i]); end
         total++; if (bus.hs_out !== 1'b0 || bus.vs_out !== 1'b1) begin
            bad++; $display("FAIL colour_sync_a_%0d hs/vs got=%b%b exp=01", i, bus.hs_out, bus.vs_out);
         end
         drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
         total++; if (bus.hs_out !== 1'b1 || bus.vs_out !== 1'b0) begin
            bad++; $display("FAIL colour_sync_b_%0d hs/vs got=%b%b exp=10", i, bus.hs_out, bus.vs_out);
         end
         rom_force = 1'b0;
      end
   endtask

   task automatic test_hold();
      drive(20, 20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(300, 200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         idle_clocks(1);
         total++; if (bus.rom_addr !== 15'(m_addr) || bus.rgb !== m_rgb ||
                      bus.hs_out !== m_hs_o || bus.vs_out !== m_vs_o) begin
            bad++; $display("FAIL hold_%0d addr=%0d/%0d rgb=%h/%h hs=%b/%b vs=%b/%b", i,
                            bus.rom_addr, m_addr, bus.rgb, m_rgb, bus.hs_out, m_hs_o, bus.vs_out, m_vs_o);
         end
      end
   endtask

   task automatic test_scroll();
      apply_reset();
`ifdef BG_SCROLL_EN
      for (int i = 0; i < 3; i++) frame_edge(1'b1);
      total++; if (bus.x_off !== 8'd3) begin bad++; $display("FAIL scroll_3 got=%0d exp=3", bus.x_off); end
      for (int i = 0; i < 157; i++) frame_edge(1'b1);
      total++; if (bus.x_off !== 8'd0) begin bad++; $display("FAIL scroll_160 got=%0d exp=0", bus.x_off); end
      for (int i = 0; i < 5; i++) frame_edge(1'b0);
      total++; if (bus.x_off !== 8'd0) begin bad++; $display("FAIL scroll_stopped got=%0d exp=0", bus.x_off); end
      drive(0, 500, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      total++; if (bus.x_off !== 8'd1) begin bad++; $display("FAIL scroll_held_low got=%0d exp=1", bus.x_off); end
      apply_reset();
      for (int i = 0; i < 10; i++) frame_edge(1'b1);
      total++; if (bus.x_off !== 8'd10) begin bad++; $display("FAIL scroll_10 got=%0d exp=10", bus.x_off); end
      drive(600, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd0) begin bad++; $display("FAIL wrap_px0 got=%0d exp=0", bus.rom_addr); end
      drive(596, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.rom_addr !== 15'd479) begin bad++; $display("FAIL wrap_px159 got=%0d exp=479", bus.rom_addr); end
`else
      for (int i = 0; i < 20; i++) frame_edge(1'b1);
      total++; if (bus.x_off !== 8'd0) begin bad++; $display("FAIL noscroll_xoff got=%0d exp=0", bus.x_off); end
      drive(600, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      total++; if (bus.rom_addr !== 15'd150) begin bad++; $display("FAIL noscroll_addr got=%0d exp=150", bus.rom_addr); end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int c, r;
         bit von, hs, vs, rn, pe;
         c   = $urandom_range(799);
         r   = $urandom_range(524);
         von = (c < 640 && r < 480);
         hs  = ($urandom_range(3) != 0);
         vs  = ($urandom_range(5) != 0);
         rn  = ($urandom_range(3) != 0);
         pe  = ($urandom_range(4) != 0);
         drive(c, r, von, hs, vs, rn, pe);
         if ($urandom_range(3) == 0) idle_clocks($urandom_range(1, 3));
         total++; if (bus.rom_addr !== 15'(m_addr)) begin bad++; $display("FAIL rand_addr i=%0d got=%0d exp=%0d", i, bus.rom_addr, m_addr); end
         total++; if (bus.rgb !== m_rgb) begin bad++; $display("FAIL rand_rgb i=%0d got=%h exp=%h", i, bus.rgb, m_rgb); end
         total++; if (bus.hs_out !== m_hs_o) begin bad++; $display("FAIL rand_hs i=%0d got=%b exp=%b", i, bus.hs_out, m_hs_o); end
         total++; if (bus.vs_out !== m_vs_o) begin bad++; $display("FAIL rand_vs i=%0d got=%b exp=%b", i, bus.vs_out, m_vs_o); end
         total++; if (bus.x_off !== 8'(m_xoff)) begin bad++; $display("FAIL rand_xoff i=%0d got=%0d exp=%0d", i, bus.x_off, m_xoff); end
      end
   endtask

   initial begin
      bus.pix_en = 1'b0; bus.col = '0; bus.row = '0; bus.video_on = 1'b0;
      bus.hs_in = 1'b1; bus.vs_in = 1'b1; bus.run = 1'b0;
      model_reset();
      test_reset();
      test_address();
      test_colour();
      test_hold();
      test_scroll();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
